// File: rtl/rip_bram_port_arbiter_if.sv
// Requester-side bus of the BRAM port-1 arbiter.
// The master modport is the requester side, the slave modport is the arbiter.
// The fields are vectors with one bit or one slice per requester; requester i
// owns addr slice [i*ADDR_WIDTH +: ADDR_WIDTH] and wdata slice [i*DATA_WIDTH +: DATA_WIDTH].
interface rip_bram_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int N_REQ      = 2
);
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0]            req_we;
  logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [N_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [N_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]       rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/rip_bram_port_arbiter.sv
// Arbiter for read/write port 1 of the 2R/1W block RAM.
// Optional zero-fill sweep of the whole RAM after reset, then one access per
// cycle to a single granted requester, with the response one cycle later.
// Build option: define RIP_BRAM_ARB_ROUND_ROBIN_EN for round-robin priority;
// without it the lowest-index valid requester always wins.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_INIT | zero-fill sweep, one write per cycle, no grants
// S_RUN  | normal arbitration, init_done high
module rip_bram_port_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 10,
  parameter int N_REQ         = 2,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  rip_bram_port_arbiter_if.slave bus,
  output logic                  init_done,
  output logic                  bram_en_1,
  output logic                  bram_we_1,
  output logic [ADDR_WIDTH-1:0] bram_addr_1,
  output logic [DATA_WIDTH-1:0] bram_din_1,
  input  logic [DATA_WIDTH-1:0] bram_dout_1
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                  state;
  logic [ADDR_WIDTH:0]     sweep_cnt;
  logic                    init_done_q;
  logic [N_REQ-1:0]        rsp_grant_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [ADDR_WIDTH-1:0]   addr_hold_q;
  logic [DATA_WIDTH-1:0]   din_hold_q;

  logic                    grant_any;
  logic [PTR_W-1:0]        grant_idx;
  logic [N_REQ-1:0]        grant_oh;
  logic                    hs;
  logic                    sweeping;
  logic                    rsp_live;

`ifdef RIP_BRAM_ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0]        rr_ptr;
  int                      cand;
  logic [PTR_W-1:0]        cand_idx;

  // Round-robin search starting at the pointer, wrapping modulo N_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = PTR_W'(cand);
      if (!grant_any && bus.req_valid[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // Pointer moves just past the requester that completed a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (hs) begin
      if (grant_idx == PTR_W'(N_REQ - 1)) rr_ptr <= '0;
      else                                rr_ptr <= grant_idx + PTR_W'(1);
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest valid index as winner.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[k]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(k);
      end
    end
  end
`endif

  // One-hot grant, only in RUN and never while reset is asserted.
  always_comb begin
    grant_oh = '0;
    if (state == S_RUN && !rst && grant_any) grant_oh[grant_idx] = 1'b1;
  end

  assign hs       = |grant_oh;
  assign sweeping = (INIT_ON_RESET != 0) && (state == S_INIT) && !rst && !sweep_cnt[ADDR_WIDTH];
  assign rsp_live = !rst && (|rsp_grant_q);

  // Port-1 drive: sweep write, granted access, or held bus when idle.
  always_comb begin
    bram_en_1   = sweeping | hs;
    bram_we_1   = sweeping | (hs & bus.req_we[grant_idx]);
    bram_addr_1 = addr_hold_q;
    bram_din_1  = din_hold_q;
    if (sweeping) begin
      bram_addr_1 = sweep_cnt[ADDR_WIDTH-1:0];
      bram_din_1  = '0;
    end else if (hs) begin
      bram_addr_1 = bus.req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
      bram_din_1  = bus.req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Registered state is masked by rst so outputs read as reset values at once.
  assign bus.req_ready = grant_oh;
  assign bus.rsp_valid = rst ? '0 : rsp_grant_q;
  assign bus.rsp_rdata = rsp_live ? bram_dout_1 : rsp_rdata_q;
  assign init_done     = init_done_q & ~rst;

  // Main FSM: sweep counter, INIT->RUN transition, registered response strobe.
  // With INIT_ON_RESET=0 reset lands directly in RUN so the first cycle after
  // reset can already grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_cnt   <= '0;
      rsp_grant_q <= '0;
      if (INIT_ON_RESET != 0) begin
        state       <= S_INIT;
        init_done_q <= 1'b0;
      end else begin
        state       <= S_RUN;
        init_done_q <= 1'b1;
      end
    end else begin
      rsp_grant_q <= grant_oh;
      case (state)
        S_INIT: begin
          sweep_cnt <= sweep_cnt + CNT_ONE;
          if (sweep_cnt[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}}) begin
            state       <= S_RUN;
            init_done_q <= 1'b1;
          end
        end
        S_RUN: begin
          state <= S_RUN;
        end
        default: begin
          state       <= S_INIT;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Hold the last driven address/data so the idle bus does not toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_hold_q <= '0;
      din_hold_q  <= '0;
    end else if (bram_en_1) begin
      addr_hold_q <= bram_addr_1;
      din_hold_q  <= bram_din_1;
    end
  end

  // Keep the last response data visible outside response cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata_q <= '0;
    end else if (rsp_live) begin
      rsp_rdata_q <= bram_dout_1;
    end
  end

endmodule

// File: tb/tb_rip_bram_port_arbiter.sv
module tb_rip_bram_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 2;

  logic clk;
  logic rst;
  logic preload;

  rip_bram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_REQ(NR)) ifa ();
  rip_bram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_REQ(NR)) ifb ();

  logic          init_done_a, en_a, we_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] din_a, dout_a;
  logic          init_done_b, en_b, we_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] din_b, dout_b;

  rip_bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_REQ(NR), .INIT_ON_RESET(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .init_done(init_done_a),
    .bram_en_1(en_a), .bram_we_1(we_a), .bram_addr_1(addr_a),
    .bram_din_1(din_a), .bram_dout_1(dout_a)
  );

  rip_bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_REQ(NR), .INIT_ON_RESET(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .init_done(init_done_b),
    .bram_en_1(en_b), .bram_we_1(we_b), .bram_addr_1(addr_b),
    .bram_din_1(din_b), .bram_dout_1(dout_b)
  );

  // Read-first BRAM models with registered output
  logic [DW-1:0] mem_a [16];
  logic [DW-1:0] mem_b [16];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem_a[i] <= 32'hFFFF_FFFF;
    end else if (en_a) begin
      dout_a <= mem_a[addr_a];
      if (we_a) mem_a[addr_a] <= din_a;
    end
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem_b[i] <= 32'h0101_0101 * i;
    end else if (en_b) begin
      dout_b <= mem_b[addr_b];
      if (we_b) mem_b[addr_b] <= din_b;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int         due;
    logic [1:0] rv;
    logic [31:0] rd;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  bit            mon_en = 1'b0;
  logic [DW-1:0] model_a [16];
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_din;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Response monitor: pop the scoreboard on the due cycle, otherwise no strobe allowed
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        n_checks++;
        assert ({ifa.rsp_valid, ifa.rsp_rdata} === {mon_e.rv, mon_e.rd}) n_pass++;
        else $error("FAIL rsp cyc=%0d observed=%b/%h expected=%b/%h",
                    cyc, ifa.rsp_valid, ifa.rsp_rdata, mon_e.rv, mon_e.rd);
      end else begin
        n_checks++;
        assert (ifa.rsp_valid === 2'b00) n_pass++;
        else $error("FAIL rsp_idle cyc=%0d observed=%b expected=00", cyc, ifa.rsp_valid);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    ifa.req_valid[i]           = v;
    ifa.req_we[i]              = w;
    ifa.req_addr[i*AW +: AW]   = a;
    ifa.req_wdata[i*DW +: DW]  = d;
  endtask

  // Called at a negedge: checks grant and port-1 drive, queues the expected response
  task automatic check_grant(input string tag, input logic [1:0] exp_ready, input bit push);
    int            g;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          w;
    exp_t          e;
    if (exp_ready == 2'b00) begin
      chk(tag, {ifa.req_ready, en_a, we_a, addr_a, din_a},
               {2'b00, 1'b0, 1'b0, last_addr, last_din});
    end else begin
      g = exp_ready[1] ? 1 : 0;
      a = ifa.req_addr[g*AW +: AW];
      d = ifa.req_wdata[g*DW +: DW];
      w = ifa.req_we[g];
      chk(tag, {ifa.req_ready, en_a, we_a, addr_a, din_a}, {exp_ready, 1'b1, w, a, d});
      if (push) begin
        e.due = cyc + 1;
        e.rv  = exp_ready;
        e.rd  = model_a[a];
        sb.push_back(e);
      end
      if (w) model_a[a] = d;
      last_addr = a;
      last_din  = d;
    end
  endtask

  task automatic sweep_check(input string tag, input bit with_b);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk(tag, {ifa.req_ready, init_done_a, en_a, we_a, addr_a, din_a},
               {2'b00, 1'b0, 1'b1, 1'b1, 4'(i), 32'h0});
      if (with_b && i == 0)
        chk("b_first_grant", {ifb.req_ready, init_done_b, en_b, we_b, addr_b},
                             {2'b01, 1'b1, 1'b1, 1'b0, 4'd3});
      if (with_b && i == 1)
        chk("b_rsp", {ifb.req_ready, ifb.rsp_valid, ifb.rsp_rdata}, {2'b00, 2'b01, 32'h0303_0303});
      if (with_b && i == 2)
        chk("b_rsp_once", {30'd0, ifb.rsp_valid}, 32'd0);
      tick();
      if (with_b && i == 0) ifb.req_valid = 2'b00;
    end
    for (int i = 0; i < 16; i++) model_a[i] = '0;
    last_addr = 4'hF;
    last_din  = '0;
  endtask

  logic [1:0] exp_g;

  initial begin
    rst = 1'b1;
    preload = 1'b1;
    ifa.req_valid = '0; ifa.req_we = '0; ifa.req_addr = '0; ifa.req_wdata = '0;
    ifb.req_valid = '0; ifb.req_we = '0; ifb.req_addr = '0; ifb.req_wdata = '0;
    tick();
    tick();
    // req1 of A waits through the sweep; B requests during reset
    set_req(1, 1'b1, 1'b0, 4'd9, 32'h0);
    ifb.req_valid = 2'b01;
    ifb.req_addr  = {4'd0, 4'd3};
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_a", {ifa.req_ready, ifa.rsp_valid, init_done_a, en_a, we_a}, 7'd0);
    chk("reset_b", {ifb.req_ready, init_done_b, en_b}, 4'd0);
    tick();
    rst = 1'b0;
    preload = 1'b0;

    sweep_check("sweep1", 1'b1);

    // First RUN cycle: pending req1 granted
    @(negedge clk);
    chk("init_done_rise", {31'd0, init_done_a}, 32'd1);
    check_grant("pending_grant", 2'b10, 1'b1);
    tick();
    set_req(1, 1'b0, 1'b0, 4'd0, 32'h0);
    set_req(0, 1'b1, 1'b1, 4'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    check_grant("wr5", 2'b01, 1'b1);
    tick();
    set_req(0, 1'b1, 1'b0, 4'd5, 32'h0);
    @(negedge clk);
    check_grant("rd5", 2'b01, 1'b1);
    tick();
    set_req(0, 1'b0, 1'b0, 4'd0, 32'h0);
    set_req(1, 1'b1, 1'b0, 4'd5, 32'h0);
    @(negedge clk);
    check_grant("rd5_req1", 2'b10, 1'b1);
    tick();

    // Both requesters held valid for four cycles
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, 1'b1, 4'd1, 32'hA000_0000 | k);
      set_req(1, 1'b1, 1'b1, 4'd2, 32'hB000_0000 | k);
`ifdef RIP_BRAM_ARB_ROUND_ROBIN_EN
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      @(negedge clk);
      check_grant($sformatf("contend%0d", k), exp_g, 1'b1);
      tick();
    end
    set_req(0, 1'b0, 1'b0, 4'd0, 32'h0);
    set_req(1, 1'b1, 1'b1, 4'd2, 32'hB000_0005);
    @(negedge clk);
    check_grant("req1_after_drop", 2'b10, 1'b1);
    tick();
    set_req(1, 1'b0, 1'b0, 4'd0, 32'h0);
    @(negedge clk);
    check_grant("idle_hold", 2'b00, 1'b1);
    tick();
    set_req(0, 1'b1, 1'b0, 4'd1, 32'h0);
    set_req(1, 1'b1, 1'b0, 4'd2, 32'h0);
    @(negedge clk);
    check_grant("readback0", 2'b01, 1'b1);
    tick();
    set_req(0, 1'b0, 1'b0, 4'd0, 32'h0);
    @(negedge clk);
    check_grant("readback1", 2'b10, 1'b1);
    tick();

    // Reset in the cycle after a read grant drops the response
    set_req(1, 1'b0, 1'b0, 4'd0, 32'h0);
    set_req(0, 1'b1, 1'b0, 4'd1, 32'h0);
    @(negedge clk);
    check_grant("rst_grant", 2'b01, 1'b0);
    tick();
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 4'd0, 32'h0);
    @(negedge clk);
    chk("rst_drop", {ifa.req_ready, ifa.rsp_valid, init_done_a, en_a, we_a}, 7'd0);
    tick();
    rst = 1'b0;
    sweep_check("sweep2", 1'b0);
    @(negedge clk);
    chk("init_done_rise2", {31'd0, init_done_a}, 32'd1);
    check_grant("post_idle", 2'b00, 1'b1);
    tick();
    set_req(0, 1'b1, 1'b0, 4'd1, 32'h0);
    @(negedge clk);
    check_grant("rd1_zero", 2'b01, 1'b1);
    tick();
    set_req(0, 1'b0, 1'b0, 4'd0, 32'h0);
    set_req(1, 1'b1, 1'b0, 4'd2, 32'h0);
    @(negedge clk);
    check_grant("rd2_zero", 2'b10, 1'b1);
    tick();
    set_req(1, 1'b0, 1'b0, 4'd0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rip_bram_port_arbiter.md
Name: rip_bram_port_arbiter

Overview:
- Shares read/write port 1 of the team's 2-read/1-write block RAM between N_REQ requesters, e.g. core load/store and the reservoir update engine.
- Runs an optional zero-fill sweep of the whole RAM after reset.
- Issues at most one access per cycle and returns a one-cycle-latency response to the requester that was granted.
- Sits between the requesters and the BRAM. BRAM port 2 (read-only) is not touched by this block.

Parameters:
- DATA_WIDTH, 32: BRAM word width.
- ADDR_WIDTH, 10: BRAM address width; depth is 2**ADDR_WIDTH.
- N_REQ, 2: number of requesters, range 2..8.
- INIT_ON_RESET, 1: 1 = zero-fill the RAM after reset; 0 = go straight to RUN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  request valid, one bit per requester.
- req_ready  out  N_REQ  grant; at most one bit high per cycle.
- req_we  in  N_REQ  1 = write, 0 = read.
- req_addr  in  N_REQ*ADDR_WIDTH  address; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  N_REQ*DATA_WIDTH  write data, sliced the same way.
- rsp_valid  out  N_REQ  response strobe to the requester granted in the previous cycle.
- rsp_rdata  out  DATA_WIDTH  shared response data.
- init_done  out  1  high once the block is in RUN.
- bram_en_1, bram_we_1  out  1  BRAM port-1 enable / write enable.
- bram_addr_1  out  ADDR_WIDTH  BRAM port-1 address.
- bram_din_1  out  DATA_WIDTH  BRAM port-1 write data.
- bram_dout_1  in  DATA_WIDTH  BRAM port-1 read data; registered inside the BRAM, read-first.

Behaviour:
- Reset values while rst=1: state=INIT, sweep counter=0, RR pointer=0, req_ready=0, rsp_valid=0, rsp grant register=0, init_done=0, bram_en_1=0, bram_we_1=0.
- States: INIT and RUN.
  - INIT → RUN after the write to address 2**ADDR_WIDTH-1.
  - If INIT_ON_RESET=0, the state leaves reset directly as RUN.
  - RUN → INIT only through rst.
- INIT:
  - bram_en_1=1, bram_we_1=1, bram_addr_1=counter, bram_din_1=0; counter increments every cycle.
  - Sweep lasts exactly 2**ADDR_WIDTH cycles.
  - req_ready=0 for the whole sweep; requests stay pending and are not dropped.
- init_done is registered: it rises in the first RUN cycle.
- RUN arbitration (combinational):
  - Candidates are all i with req_valid[i]=1.
  - Winner g is chosen per the Optional Feature; req_ready[g]=1.
  - A handshake is req_valid[g] & req_ready[g] in the same cycle.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Handshake cycle c:
  - bram_en_1=1, bram_we_1=req_we[g], bram_addr_1 and bram_din_1 taken from slice g.
  - With no handshake, bram_en_1=0, bram_we_1=0, addr/din don't-care. They are held at their previous values to save power.
- Response in cycle c+1:
  - rsp_valid[g]=1 (one-hot); rsp_rdata=bram_dout_1.
  - For a write, the response still fires and rsp_rdata = old contents (read-first).
  - Outside response cycles rsp_rdata holds its last value.
- Back-to-back:
  - A new grant is allowed every cycle, giving full throughput.
  - A read to the address written in the previous cycle returns the new data.
  - Same-cycle conflicts cannot occur because there is a single grant.
- Reset mid-operation:
  - An in-flight response is dropped (rsp_valid=0 in the cycle after rst).
  - The sweep restarts from address 0.
- Widths: the sweep counter is ADDR_WIDTH+1 bits. The MSB marks completion, so there is no wrap back to 0.

Optional Feature:
- Macro: RIP_BRAM_ARB_ROUND_ROBIN_EN.
- Defined (round robin):
  - Priority starts at the RR pointer p and searches p, p+1, …, wrapping mod N_REQ.
  - After a handshake by g, p becomes (g+1) mod N_REQ. p is unchanged when there is no handshake.
- Undefined (fixed priority):
  - The lowest-index valid requester wins; no pointer register is built.

Test Plan:
- ADDR_WIDTH=4, INIT_ON_RESET=1, pre-load RAM with 0xFFFFFFFF, pulse rst → exactly 16 write cycles with addresses 0..15 and din=0; req_ready=0 throughout; init_done=1 on cycle 17; every subsequent read returns 0.
- After init, req0 writes 0xDEADBEEF to address 5, then reads address 5 in the next cycle → write response rsp_rdata=0x00000000, read response rsp_rdata=0xDEADBEEF, each rsp_valid[0] exactly one cycle after its grant.
- Both requesters held valid for 4 cycles with round robin defined → grants 0,1,0,1. With the macro undefined → grants 0,0,0,0 and req1 is starved until req0 drops valid.
- req1 asserts valid during INIT → held pending with no grant; granted in the first RUN cycle and its response arrives in the cycle after.
- rst asserted in the cycle after a read grant → rsp_valid stays 0, a fresh sweep starts at address 0, init_done=0.
- INIT_ON_RESET=0 → init_done=1 in the first cycle after reset releases; a request presented then is granted immediately.
